ps2_scan_code_receiver: RTL and testbench

Receives the PS/2 keyboard serial stream, checks each 11-bit frame and assembles completed keystrokes into the 32-bit `scan_codes` history that the seven-segment display controller consumes. One keystroke is recorded per key release: the make code that follows an `F0` break prefix is shifted into the history, newest in `[7:0]`. The block sits between the keyboard pins and the display path, in the single `clk` domain.

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_scan_code_receiver_if.sv | 18 +
 rtl/ps2_sync_edge.sv | 35 +++
 rtl/ps2_scan_code_receiver.sv | 132 +++++++++++++
 tb/tb_ps2_scan_code_receiver.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame FSM encoding and scan-code constants, also
// used by the seven-segment display controller.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_PARITY,
    ST_STOP
  } frame_state_t;

  localparam logic [7:0] SCAN_CODE_BREAK    = 8'hF0;
  localparam logic [7:0] SCAN_CODE_EXTENDED = 8'hE0;

  // Index is the decimal digit the key produces.
  localparam logic [7:0] SCAN_CODE_DIGIT [10] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
    8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46
  };

endpackage

// File: rtl/ps2_scan_code_receiver_if.sv
// Keyboard pins and keystroke-history outputs of the PS/2 receiver.
interface ps2_scan_code_receiver_if;
  logic        kb_clk;
  logic        kb_data;
  logic [31:0] scan_codes;
  logic        code_valid;
  logic        frame_error;

  modport master (
    output kb_clk, kb_data,
    input  scan_codes, code_valid, frame_error
  );

  modport slave (
    input  kb_clk, kb_data,
    output scan_codes, code_valid, frame_error
  );
endinterface

// File: rtl/ps2_sync_edge.sv
// Brings the asynchronous PS/2 pins into the clk domain and flags kb_clk falls.
// Flops reset to 1, the bus idle level, so reset never fabricates a fall.
module ps2_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic kb_clk,
  input  logic kb_data,
  output logic kb_data_s,
  output logic fall
);
  logic [1:0] clk_sync_q, clk_sync_d;
  logic [1:0] data_sync_q, data_sync_d;
  logic       kb_clk_d_q, kb_clk_d_d;

  always_comb begin
    clk_sync_d  = {clk_sync_q[0], kb_clk};
    data_sync_d = {data_sync_q[0], kb_data};
    kb_clk_d_d  = clk_sync_q[1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      kb_clk_d_q  <= 1'b1;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      kb_clk_d_q  <= kb_clk_d_d;
    end
  end

  assign kb_data_s = data_sync_q[1];
  assign fall      = kb_clk_d_q & ~clk_sync_q[1];
endmodule

// File: rtl/ps2_scan_code_receiver.sv
// PS/2 keyboard receiver: checks 11-bit frames and records each released key
// into a 4-deep scan-code history, newest byte in [7:0].
//   state  | meaning
//   IDLE   | waiting for a start bit
//   SHIFT  | collecting 8 data bits LSB-first
//   PARITY | next fall carries the odd-parity bit
//   STOP   | next fall carries the stop bit; frame judged here
module ps2_scan_code_receiver
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic clk,
  input  logic reset,
  ps2_scan_code_receiver_if.slave bus
);
  localparam int unsigned   TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_CYCLES - 1);

  logic kb_data_s;
  logic fall;

  frame_state_t  state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] timeout_cnt_q, timeout_cnt_d;
  logic          break_pending_q, break_pending_d;
  logic [31:0]   scan_codes_q, scan_codes_d;
  logic          code_valid_q, code_valid_d;
  logic          frame_error_q, frame_error_d;
  logic          byte_ok;

  ps2_sync_edge u_sync (
    .clk       (clk),
    .reset     (reset),
    .kb_clk    (bus.kb_clk),
    .kb_data   (bus.kb_data),
    .kb_data_s (kb_data_s),
    .fall      (fall)
  );

  always_comb begin
    state_d         = state_q;
    bit_cnt_d       = bit_cnt_q;
    shift_d         = shift_q;
    parity_d        = parity_q;
    timeout_cnt_d   = timeout_cnt_q;
    break_pending_d = break_pending_q;
    scan_codes_d    = scan_codes_q;
    code_valid_d    = 1'b0;
    frame_error_d   = 1'b0;
    byte_ok         = 1'b0;

    if (state_q == ST_IDLE) begin
      timeout_cnt_d = '0;
      if (fall && !kb_data_s) begin
        bit_cnt_d     = '0;
        timeout_cnt_d = TO_LOAD;
        state_d       = ST_SHIFT;
      end
    end else if (fall) begin
      timeout_cnt_d = TO_LOAD;
      case (state_q)
        ST_SHIFT: begin
          shift_d   = {kb_data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          parity_d = kb_data_s;
          state_d  = ST_STOP;
        end
        default: begin
          byte_ok = kb_data_s & (^{shift_q, parity_q});
          if (!byte_ok) begin
            frame_error_d   = 1'b1;
            break_pending_d = 1'b0;
          end
          timeout_cnt_d = '0;
          state_d       = ST_IDLE;
        end
      endcase
    end else if (timeout_cnt_q == '0) begin
      // Keyboard went quiet mid-frame: drop the partial byte and resync.
      frame_error_d   = 1'b1;
      break_pending_d = 1'b0;
      shift_d         = '0;
      state_d         = ST_IDLE;
    end else begin
      timeout_cnt_d = timeout_cnt_q - TW'(1);
    end

    if (byte_ok) begin
      if (shift_q == SCAN_CODE_BREAK) begin
        break_pending_d = 1'b1;
      end else if (shift_q != SCAN_CODE_EXTENDED && break_pending_q) begin
        scan_codes_d    = {scan_codes_q[23:0], shift_q};
        code_valid_d    = 1'b1;
        break_pending_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      bit_cnt_q       <= '0;
      shift_q         <= '0;
      parity_q        <= 1'b0;
      timeout_cnt_q   <= '0;
      break_pending_q <= 1'b0;
      scan_codes_q    <= '0;
      code_valid_q    <= 1'b0;
      frame_error_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      parity_q        <= parity_d;
      timeout_cnt_q   <= timeout_cnt_d;
      break_pending_q <= break_pending_d;
      scan_codes_q    <= scan_codes_d;
      code_valid_q    <= code_valid_d;
      frame_error_q   <= frame_error_d;
    end
  end

  assign bus.scan_codes  = scan_codes_q;
  assign bus.code_valid  = code_valid_q;
  assign bus.frame_error = frame_error_q;
endmodule

// File: tb/tb_ps2_scan_code_receiver.sv
// Bench for ps2_scan_code_receiver: directed keystroke scenarios plus random
// frame streams checked against a frame-level keystroke model.
module tb_ps2_scan_code_receiver;
  import ps2_pkg::*;

  localparam int TO = 200;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   valid_cnt = 0;
  int   err_cnt   = 0;
  int   half      = 16;

  logic [31:0] m_hist;
  logic        m_pending;

  ps2_scan_code_receiver_if bus ();

  ps2_scan_code_receiver #(.TIMEOUT_CYCLES(TO)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.code_valid)  valid_cnt++;
    if (bus.frame_error) err_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Keystroke rules applied to one whole frame; kind 0 good, 1 bad parity, 2 bad stop.
  task automatic model_frame(input logic [7:0] b, input int kind, output int ev, output int ee);
    ev = 0;
    ee = 0;
    if (kind != 0) begin
      ee = 1;
      m_pending = 1'b0;
    end else if (b == 8'hF0) begin
      m_pending = 1'b1;
    end else if (b != 8'hE0) begin
      if (m_pending) begin
        m_hist = {m_hist[23:0], b};
        ev = 1;
      end
      m_pending = 1'b0;
    end
  endtask

  task automatic send_bit(input logic v);
    @(negedge clk);
    bus.kb_data = v;
    repeat (half) @(negedge clk);
    bus.kb_clk = 1'b0;
    repeat (half) @(negedge clk);
    bus.kb_clk = 1'b1;
  endtask

  task automatic do_frame(input logic [7:0] b, input int kind);
    logic [10:0] bits;
    int v0, e0, ev, ee;
    v0 = valid_cnt;
    e0 = err_cnt;
    bits = {(kind == 2) ? 1'b0 : 1'b1, (kind == 1) ? (^b) : ~(^b), b, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(bits[i]);
    bus.kb_data = 1'b1;
    repeat (8) @(negedge clk);
    model_frame(b, kind, ev, ee);
    chk($sformatf("valid[%02h]", b), 32'(valid_cnt - v0), 32'(ev));
    chk($sformatf("error[%02h]", b), 32'(err_cnt - e0), 32'(ee));
    chk($sformatf("scan[%02h]", b), bus.scan_codes, m_hist);
  endtask

  initial begin
    int v0, e0;
    logic [7:0] b;
    int r, kind;
    bus.kb_clk  = 1'b1;
    bus.kb_data = 1'b1;
    reset       = 1'b1;
    m_hist      = '0;
    m_pending   = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_scan", bus.scan_codes, 32'h0);
    chk("rst_valid", {31'b0, bus.code_valid}, 32'h0);
    chk("rst_error", {31'b0, bus.frame_error}, 32'h0);

    // Make, break, make of the same key records one keystroke.
    do_frame(8'h16, 0);
    do_frame(8'hF0, 0);
    do_frame(8'h16, 0);
    chk("single_key", bus.scan_codes, 32'h0000_0016);

    v0 = valid_cnt;
    for (int i = 0; i < 5; i++) begin
      do_frame(8'hF0, 0);
      do_frame(SCAN_CODE_DIGIT[i], 0);
    end
    chk("five_pushes", 32'(valid_cnt - v0), 32'd5);
    chk("history_wrap", bus.scan_codes, 32'h161E_2625);

    do_frame(8'hF0, 0);
    do_frame(8'h1E, 1);
    do_frame(8'h1E, 0);

    do_frame(8'hE0, 0);
    do_frame(8'hF0, 0);
    do_frame(8'h3D, 0);
    chk("ext_low_byte", {24'h0, bus.scan_codes[7:0]}, 32'h3D);

    // Start bit plus four data bits, then silence.
    half = 12;
    e0 = err_cnt;
    v0 = valid_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    @(negedge clk);
    bus.kb_data = 1'b1;
    repeat (half) @(negedge clk);
    bus.kb_clk = 1'b0;
    for (int k = 1; k <= TO + 4; k++) begin
      @(posedge clk);
      #1;
      if (k == half) bus.kb_clk = 1'b1;
      if (k == TO + 2) chk("to_early", {31'b0, bus.frame_error}, 32'h0);
      if (k == TO + 3) chk("to_fire", {31'b0, bus.frame_error}, 32'h1);
      if (k == TO + 4) chk("to_pulse", {31'b0, bus.frame_error}, 32'h0);
    end
    chk("to_count", 32'(err_cnt - e0), 32'd1);
    chk("to_novalid", 32'(valid_cnt - v0), 32'd0);
    m_pending = 1'b0;
    do_frame(8'hF0, 0);
    do_frame(8'h46, 0);

    // Reset in the middle of a frame's data bits, with a break pending.
    do_frame(8'hF0, 0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_scan", bus.scan_codes, 32'h0);
    chk("mid_rst_valid", {31'b0, bus.code_valid}, 32'h0);
    chk("mid_rst_error", {31'b0, bus.frame_error}, 32'h0);
    m_hist    = '0;
    m_pending = 1'b0;
    bus.kb_data = 1'b1;
    repeat (4) @(negedge clk);
    do_frame(8'h36, 0);
    do_frame(8'hF0, 0);
    do_frame(8'h36, 0);
    chk("post_rst_push", bus.scan_codes, 32'h0000_0036);

    for (int n = 0; n < 40; n++) begin
      half = $urandom_range(8, 20);
      r = $urandom_range(0, 9);
      if (r < 3)      b = 8'hF0;
      else if (r < 4) b = 8'hE0;
      else if (r < 8) b = SCAN_CODE_DIGIT[$urandom_range(0, 9)];
      else            b = 8'($urandom);
      r = $urandom_range(0, 9);
      kind = (r == 0) ? 1 : (r == 1) ? 2 : 0;
      do_frame(b, kind);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
